dmem_responder: RTL and testbench

- Data-memory responder serving the pipeline's memory-stage request port (MemRead, MemWrite, addr, wr_data, func3).
- Holds 512 bytes as 128 little-endian 32-bit words.
- Adds a ready handshake and a configurable wait-state count so multi-cycle memory timing can be modelled.
- Handles RV32I byte, halfword and word loads and stores, with sign/zero extension and alignment checking.

---
 rtl/dmem_responder_if.sv | 26 ++
 rtl/dmem_responder.sv | 194 +++++++++++++++++++
 tb/tb_dmem_responder.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Memory-stage request/response bundle between the pipeline and dmem_responder.
// master = pipeline side, slave = responder side.
interface dmem_responder_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);
  logic                  MemRead;
  logic                  MemWrite;
  logic [DM_ADDRESS-1:0] addr;
  logic [DATA_W-1:0]     wr_data;
  logic [2:0]            func3;
  logic [DATA_W-1:0]     rd_data;
  logic                  ready;
  logic                  err;
  logic                  busy;

  modport master (
    output MemRead, MemWrite, addr, wr_data, func3,
    input  rd_data, ready, err, busy
  );

  modport slave (
    input  MemRead, MemWrite, addr, wr_data, func3,
    output rd_data, ready, err, busy
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: 2**DM_ADDRESS bytes held as little-endian words,
// RV32I byte/half/word loads and stores with a ready handshake and
// WAIT_CYCLES wait states. Optional DMEM_STATS_EN adds rd_count/wr_count.
//
// state | meaning
// IDLE  | waiting for MemRead xor MemWrite (both high -> illegal, straight to RESP)
// BUSY  | wait states, inputs ignored, counter runs down to 0
// RESP  | one-cycle ready pulse with rd_data/err, then back to IDLE
module dmem_responder #(
  parameter int DM_ADDRESS  = 9,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
`ifdef DMEM_STATS_EN
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
`endif
  dmem_responder_if.slave bus
);
  localparam int WORDS = 2 ** (DM_ADDRESS - 2);
  localparam int NB    = DATA_W / 8;
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  logic [DM_ADDRESS-1:0] addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [2:0]            f3_q;
  logic                  wr_q;
  logic [DATA_W-1:0]     rd_q;
  logic                  err_q;

  logic [DATA_W-1:0] mem [WORDS];

  // In IDLE the access is taken straight from the bus (needed when the
  // request goes to RESP on its accept edge); afterwards from the captured copy.
  logic                  in_idle;
  logic [DM_ADDRESS-1:0] a_addr;
  logic [DATA_W-1:0]     a_data;
  logic [2:0]            a_f3;
  logic                  a_wr;
  logic                  a_both;
  logic                  enter_resp;

  assign in_idle    = (state == IDLE);
  assign a_addr     = in_idle ? bus.addr    : addr_q;
  assign a_data     = in_idle ? bus.wr_data : wdata_q;
  assign a_f3       = in_idle ? bus.func3   : f3_q;
  assign a_wr       = in_idle ? bus.MemWrite : wr_q;
  assign a_both     = in_idle && bus.MemRead && bus.MemWrite;
  assign enter_resp = (state != RESP) && (state_nxt == RESP);

  // Legality, alignment, load extraction and store merge for the current access
  logic              f3_ok, misalign, a_err;
  logic [DATA_W-1:0] word, ld_val, st_rep, st_word;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [NB-1:0]     be;

  assign word = mem[a_addr[DM_ADDRESS-1:2]];

  always_comb begin
    f3_ok = 1'b0;
    case (a_f3)
      3'd0, 3'd1, 3'd2: f3_ok = 1'b1;
      3'd4, 3'd5:       f3_ok = !a_wr;
      default:          f3_ok = 1'b0;
    endcase
    misalign = ((a_f3[1:0] == 2'b01) && a_addr[0]) ||
               ((a_f3[1:0] == 2'b10) && (a_addr[1:0] != 2'b00));
    a_err = a_both || !f3_ok || misalign;
  end

  always_comb begin
    ld_byte = word[8*a_addr[1:0] +: 8];
    ld_half = a_addr[1] ? word[31:16] : word[15:0];
    ld_val  = '0;
    if (!a_err && !a_wr) begin
      case (a_f3)
        3'd0:    ld_val = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
        3'd1:    ld_val = {{(DATA_W-16){ld_half[15]}}, ld_half};
        3'd2:    ld_val = word;
        3'd4:    ld_val = {{(DATA_W-8){1'b0}}, ld_byte};
        3'd5:    ld_val = {{(DATA_W-16){1'b0}}, ld_half};
        default: ld_val = '0;
      endcase
    end
  end

  always_comb begin
    st_rep = a_data;
    be     = '0;
    case (a_f3)
      3'd0: begin
        st_rep = {NB{a_data[7:0]}};
        be     = NB'(1) << a_addr[1:0];
      end
      3'd1: begin
        st_rep = {(NB/2){a_data[15:0]}};
        be     = a_addr[1] ? 4'b1100 : 4'b0011;
      end
      3'd2:    be = '1;
      default: be = '0;
    endcase
    for (int i = 0; i < NB; i++)
      st_word[8*i +: 8] = be[i] ? st_rep[8*i +: 8] : word[8*i +: 8];
  end

  // State register and wait counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (bus.MemRead && bus.MemWrite) begin
          state_nxt = RESP;
        end else if (bus.MemRead ^ bus.MemWrite) begin
          state_nxt = (WAIT_CYCLES == 0) ? RESP : BUSY;
          cnt_nxt   = WAIT_INIT;
        end
      end
      BUSY: begin
        if (cnt == 4'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.ready   = (state == RESP);
    bus.busy    = (state != IDLE);
    bus.rd_data = rd_q;
    bus.err     = err_q;
  end

  // Request capture in IDLE; response registers hold only for the RESP cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      wr_q    <= 1'b0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      if (in_idle && (bus.MemRead ^ bus.MemWrite)) begin
        addr_q  <= bus.addr;
        wdata_q <= bus.wr_data;
        f3_q    <= bus.func3;
        wr_q    <= bus.MemWrite;
      end
      rd_q  <= enter_resp ? ld_val : '0;
      err_q <= enter_resp ? a_err : 1'b0;
    end
  end

  // Storage is not reset; a reset before the RESP edge aborts the write
  always_ff @(posedge clk) begin
    if (!reset && enter_resp && a_wr && !a_err)
      mem[a_addr[DM_ADDRESS-1:2]] <= st_word;
  end

`ifdef DMEM_STATS_EN
  // Saturating counts of successful loads and stores
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (enter_resp && !a_err) begin
      if (!a_wr && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      if (a_wr  && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with WAIT_CYCLES=2.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  int exp_rd = 0;
  int exp_wr = 0;

  dmem_responder_if #(.DM_ADDRESS(9), .DATA_W(32)) bus ();

`ifdef DMEM_STATS_EN
  logic [15:0] rd_count, wr_count;
`endif

  dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(2)) dut (
    .clk(clk),
    .reset(reset),
`ifdef DMEM_STATS_EN
    .rd_count(rd_count),
    .wr_count(wr_count),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [8:0] a, input logic [31:0] d, input logic [2:0] f3,
                        input logic [31:0] exp_data, input logic exp_err, input int exp_lat);
    int lat;
    @(negedge clk);
    bus.MemRead  = rd;
    bus.MemWrite = wr;
    bus.addr     = a;
    bus.wr_data  = d;
    bus.func3    = f3;
    @(posedge clk);
    #1;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.addr     = 9'($urandom);
    bus.wr_data  = $urandom;
    bus.func3    = 3'($urandom);
    check({tag, "/busy"}, 32'(bus.busy), 32'd1);
    lat = 1;
    while (!bus.ready && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "/lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "/err"}, 32'(bus.err), 32'(exp_err));
    check({tag, "/data"}, bus.rd_data, exp_data);
    if (!exp_err) begin
      if (wr) exp_wr++;
      else    exp_rd++;
    end
    @(posedge clk);
    #1;
    check({tag, "/pulse"}, {30'd0, bus.ready, bus.busy}, 32'd0);
  endtask

  initial begin
    reset        = 1'b1;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.addr     = '0;
    bus.wr_data  = '0;
    bus.func3    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst/ready", 32'(bus.ready), 32'd0);
    check("rst/busy", 32'(bus.busy), 32'd0);
    check("rst/err", 32'(bus.err), 32'd0);
    check("rst/data", bus.rd_data, 32'd0);

    access("sw010",  1'b0, 1'b1, 9'h010, 32'hDEADBEEF, 3'd2, 32'h0, 1'b0, 3);
    access("lw010",  1'b1, 1'b0, 9'h010, 32'h0, 3'd2, 32'hDEADBEEF, 1'b0, 3);
    access("sw000",  1'b0, 1'b1, 9'h000, 32'h11223344, 3'd2, 32'h0, 1'b0, 3);

    access("sb011",  1'b0, 1'b1, 9'h011, 32'h00000080, 3'd0, 32'h0, 1'b0, 3);
    access("lb011",  1'b1, 1'b0, 9'h011, 32'h0, 3'd0, 32'hFFFFFF80, 1'b0, 3);
    access("lbu011", 1'b1, 1'b0, 9'h011, 32'h0, 3'd4, 32'h00000080, 1'b0, 3);
    access("lw010b", 1'b1, 1'b0, 9'h010, 32'h0, 3'd2, 32'hDEAD80EF, 1'b0, 3);

    access("sh012",  1'b0, 1'b1, 9'h012, 32'h00008001, 3'd1, 32'h0, 1'b0, 3);
    access("lh012",  1'b1, 1'b0, 9'h012, 32'h0, 3'd1, 32'hFFFF8001, 1'b0, 3);
    access("lhu012", 1'b1, 1'b0, 9'h012, 32'h0, 3'd5, 32'h00008001, 1'b0, 3);

    access("lw013",  1'b1, 1'b0, 9'h013, 32'h0, 3'd2, 32'h0, 1'b1, 3);
    access("sh001",  1'b0, 1'b1, 9'h001, 32'h0000FFFF, 3'd1, 32'h0, 1'b1, 3);
    access("f3is3",  1'b1, 1'b0, 9'h010, 32'h0, 3'd3, 32'h0, 1'b1, 3);
    access("sbu",    1'b0, 1'b1, 9'h010, 32'h0, 3'd4, 32'h0, 1'b1, 3);
    access("lw000",  1'b1, 1'b0, 9'h000, 32'h0, 3'd2, 32'h11223344, 1'b0, 3);
    access("lw010c", 1'b1, 1'b0, 9'h010, 32'h0, 3'd2, 32'h800180EF, 1'b0, 3);

    access("sw020",  1'b0, 1'b1, 9'h020, 32'hCAFEF00D, 3'd2, 32'h0, 1'b0, 3);
    @(negedge clk);
    bus.MemWrite = 1'b1;
    bus.addr     = 9'h020;
    bus.wr_data  = 32'h12345678;
    bus.func3    = 3'd2;
    @(posedge clk);
    #1;
    bus.MemWrite = 1'b0;
    check("abort/busy_before", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    #1;
    check("abort/outs", {29'd0, bus.ready, bus.busy, bus.err}, 32'd0);
    check("abort/data", bus.rd_data, 32'd0);
    @(negedge clk);
    reset  = 1'b0;
    exp_rd = 0;
    exp_wr = 0;
    access("lw020",  1'b1, 1'b0, 9'h020, 32'h0, 3'd2, 32'hCAFEF00D, 1'b0, 3);

    access("both",   1'b1, 1'b1, 9'h020, 32'hAAAAAAAA, 3'd2, 32'h0, 1'b1, 1);
    access("lw020b", 1'b1, 1'b0, 9'h020, 32'h0, 3'd2, 32'hCAFEF00D, 1'b0, 3);

    access("sw1fc",  1'b0, 1'b1, 9'h1FC, 32'h00000000, 3'd2, 32'h0, 1'b0, 3);
    access("sb1ff",  1'b0, 1'b1, 9'h1FF, 32'h000000AB, 3'd0, 32'h0, 1'b0, 3);
    access("lw1fc",  1'b1, 1'b0, 9'h1FC, 32'h0, 3'd2, 32'hAB000000, 1'b0, 3);

`ifdef DMEM_STATS_EN
    check("stats/rd", 32'(rd_count), 32'(exp_rd));
    check("stats/wr", 32'(wr_count), 32'(exp_wr));
    check("stats/rd_plan", 32'(rd_count), 32'd3);
    check("stats/wr_plan", 32'(wr_count), 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
